// File: rtl/lcd_spi_rx.sv
// lcd_spi_rx: receive side of the 4-wire SPI LCD link (SCL, MOSI, DC, CS).
// The bus pins are oversampled on CLK and bytes are rebuilt MSB first. Each
// byte is tagged as command or parameter. The block decodes the window and
// RAMWR commands, turns RAMWR payload into RGB565 pixels with coordinates
// that follow the window, tracks the sleep/display flags, and flags CS
// rising mid-byte.
//
// Ports:
//   CLK, RST           system clock, asynchronous active-high reset
//   SCL, MOSI, DC, CS  asynchronous bus pins (CS active low)
//   byte_valid/data/dc one pulse per received byte, plus the byte and its DC
//   cur_cmd            last command byte received
//   pixel_valid/data   one pulse per RGB565 pixel (first byte in [15:8])
//   pixel_x/pixel_y    coordinates of pixel_data
//   frame_done         pulses with the pixel at (XE, YE)
//   sleep_out, disp_on panel state flags
//   err_partial        pulse when CS rises with 1-7 bits shifted
module lcd_spi_rx #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] X_END_RST   = 8'd159,
  parameter logic [7:0] Y_END_RST   = 8'd79
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        SCL,
  input  logic        MOSI,
  input  logic        DC,
  input  logic        CS,
  output logic        byte_valid,
  output logic [7:0]  byte_data,
  output logic        byte_dc,
  output logic [7:0]  cur_cmd,
  output logic        pixel_valid,
  output logic [15:0] pixel_data,
  output logic [7:0]  pixel_x,
  output logic [7:0]  pixel_y,
  output logic        frame_done,
  output logic        sleep_out,
  output logic        disp_on,
  output logic        err_partial
);

  localparam logic [7:0] CMD_SLPOUT  = 8'h11;
  localparam logic [7:0] CMD_DISPOFF = 8'h28;
  localparam logic [7:0] CMD_DISPON  = 8'h29;
  localparam logic [7:0] CMD_CASET   = 8'h2A;
  localparam logic [7:0] CMD_RASET   = 8'h2B;
  localparam logic [7:0] CMD_RAMWR   = 8'h2C;

  typedef enum logic [1:0] {ST_CMD, ST_PARAM, ST_PIX_HI, ST_PIX_LO} state_t;

  // ---------------- input synchronizers ----------------
  logic [SYNC_STAGES-1:0] scl_sync, mosi_sync, dc_sync, cs_sync;
  logic scl_prev, cs_prev;

  // NOTE: the SCL and CS chains reset to their idle-high level so that a pin
  // already high when reset releases does not look like a fresh edge.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      scl_sync  <= '1;
      mosi_sync <= '0;
      dc_sync   <= '0;
      cs_sync   <= '1;
      scl_prev  <= 1'b1;
      cs_prev   <= 1'b1;
    end else begin
      scl_sync  <= {scl_sync[SYNC_STAGES-2:0], SCL};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
      dc_sync   <= {dc_sync[SYNC_STAGES-2:0], DC};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], CS};
      scl_prev  <= scl_sync[SYNC_STAGES-1];
      cs_prev   <= cs_sync[SYNC_STAGES-1];
    end
  end

  logic scl_s, mosi_s, dc_s, cs_s;
  assign scl_s  = scl_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];
  assign dc_s   = dc_sync[SYNC_STAGES-1];
  assign cs_s   = cs_sync[SYNC_STAGES-1];

  // ---------------- byte shifter ----------------
  logic [2:0] bit_cnt;
  logic [7:0] shreg;
  logic       scl_rise, cs_rise, rx_done;
  logic [7:0] rx_byte;

  // A rising CS forces cs_s high, so it can never coincide with a qualified SCL edge.
  assign scl_rise = scl_s & ~scl_prev & ~cs_s;
  assign cs_rise  = cs_s & ~cs_prev;
  assign rx_byte  = {shreg[6:0], mosi_s};
  assign rx_done  = scl_rise && (bit_cnt == 3'd7);

  // NOTE: state registers use non-blocking assignments only, so every block
  // sees the pre-edge value of every other register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      bit_cnt     <= 3'd0;
      shreg       <= 8'h00;
      byte_valid  <= 1'b0;
      byte_data   <= 8'h00;
      byte_dc     <= 1'b0;
      err_partial <= 1'b0;
    end else begin
      byte_valid  <= 1'b0;
      err_partial <= 1'b0;
      if (cs_rise) begin
        err_partial <= (bit_cnt != 3'd0);
        bit_cnt     <= 3'd0;
      end else if (scl_rise) begin
        shreg   <= rx_byte;
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          byte_valid <= 1'b1;
          byte_data  <= rx_byte;
          byte_dc    <= dc_s;
        end
      end
    end
  end

  // ---------------- window and flag registers ----------------
  // These follow the registered byte, so they change the cycle after byte_valid.
  // Bytes arrive at least 16 CLK apart, so the pixel path below always sees settled values.
  logic [7:0] xs, xe, ys, ye;
  logic [2:0] param_idx;
  logic       in_window_cmd;

  assign in_window_cmd = (cur_cmd == CMD_CASET) || (cur_cmd == CMD_RASET);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cur_cmd   <= 8'h00;
      sleep_out <= 1'b0;
      disp_on   <= 1'b0;
      param_idx <= 3'd0;
      xs        <= 8'h00;
      ys        <= 8'h00;
      xe        <= X_END_RST;
      ye        <= Y_END_RST;
    end else if (byte_valid) begin
      if (!byte_dc) begin
        cur_cmd   <= byte_data;
        param_idx <= 3'd0;
        case (byte_data)
          CMD_SLPOUT:  sleep_out <= 1'b1;
          CMD_DISPON:  disp_on   <= 1'b1;
          CMD_DISPOFF: disp_on   <= 1'b0;
          default:     ;
        endcase
      end else if (in_window_cmd && (param_idx != 3'd4)) begin
        param_idx <= param_idx + 3'd1;
        // Coordinates are 8 bits wide: only the low byte of each pair is kept.
        if (param_idx == 3'd1) begin
          if (cur_cmd == CMD_CASET) xs <= byte_data;
          else                      ys <= byte_data;
        end else if (param_idx == 3'd3) begin
          if (cur_cmd == CMD_CASET) xe <= byte_data;
          else                      ye <= byte_data;
        end
      end
    end
  end

  // ---------------- decode FSM and pixel path ----------------
  // Acts on the byte as it completes, so the pixel pulse lines up with
  // byte_valid of its low byte.
  state_t     state;
  logic [7:0] pix_hi, x, y;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= ST_CMD;
      pix_hi      <= 8'h00;
      x           <= 8'h00;
      y           <= 8'h00;
      pixel_valid <= 1'b0;
      pixel_data  <= 16'h0000;
      pixel_x     <= 8'h00;
      pixel_y     <= 8'h00;
      frame_done  <= 1'b0;
    end else begin
      pixel_valid <= 1'b0;
      frame_done  <= 1'b0;
      if (rx_done) begin
        if (!dc_s) begin
          // Any command drops a pending high byte.
          case (rx_byte)
            CMD_RAMWR: begin
              x     <= xs;
              y     <= ys;
              state <= ST_PIX_HI;
            end
            CMD_CASET, CMD_RASET: state <= ST_PARAM;
            default:              state <= ST_CMD;
          endcase
        end else begin
          case (state)
            ST_PIX_HI: begin
              pix_hi <= rx_byte;
              state  <= ST_PIX_LO;
            end
            ST_PIX_LO: begin
              pixel_valid <= 1'b1;
              pixel_data  <= {pix_hi, rx_byte};
              pixel_x     <= x;
              pixel_y     <= y;
              state       <= ST_PIX_HI;
              // Wrap only on equality: a window with XS > XE counts through 255.
              if (x == xe) begin
                x <= xs;
                if (y == ye) begin
                  y          <= ys;
                  frame_done <= 1'b1;
                end else begin
                  y <= y + 8'd1;
                end
              end else begin
                x <= x + 8'd1;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_lcd_spi_rx.sv
// Testbench for lcd_spi_rx. A stimulus process drives the SPI pins and
// pushes the expected bytes, pixels and error pulses into scoreboards. A
// monitor checks each DUT output pulse on the falling CLK edge against the
// scoreboard. Flag and state values are checked directly at quiet points.
module tb_lcd_spi_rx;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        SCL = 1'b0;
  logic        MOSI = 1'b0;
  logic        DC = 1'b0;
  logic        CS = 1'b1;
  logic        byte_valid, byte_dc, pixel_valid, frame_done;
  logic        sleep_out, disp_on, err_partial;
  logic [7:0]  byte_data, cur_cmd, pixel_x, pixel_y;
  logic [15:0] pixel_data;

  lcd_spi_rx dut (
    .CLK(CLK), .RST(RST), .SCL(SCL), .MOSI(MOSI), .DC(DC), .CS(CS),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_dc(byte_dc),
    .cur_cmd(cur_cmd), .pixel_valid(pixel_valid), .pixel_data(pixel_data),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .frame_done(frame_done),
    .sleep_out(sleep_out), .disp_on(disp_on), .err_partial(err_partial)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [7:0] data;
    logic       dc;
  } byte_t;

  typedef struct packed {
    logic [15:0] data;
    logic [7:0]  x;
    logic [7:0]  y;
    logic        fd;
  } pix_t;

  byte_t byte_q[$];
  pix_t  pix_q[$];
  int    err_exp = 0;
  int    total = 0;
  int    bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    total++;
    bad++;
    $display("FAIL %s: pulse with nothing expected", name);
  endtask

  // ---------------- monitor ----------------
  byte_t mb;
  pix_t  mp;

  always @(negedge CLK) begin
    if (!RST) begin
      if (byte_valid) begin
        if (byte_q.size() == 0) unexpected("byte_valid");
        else begin
          mb = byte_q.pop_front();
          check("byte_data", {24'h0, byte_data}, {24'h0, mb.data});
          check("byte_dc", {31'h0, byte_dc}, {31'h0, mb.dc});
        end
      end
      if (pixel_valid) begin
        if (pix_q.size() == 0) unexpected("pixel_valid");
        else begin
          mp = pix_q.pop_front();
          check("pixel_data", {16'h0, pixel_data}, {16'h0, mp.data});
          check("pixel_x", {24'h0, pixel_x}, {24'h0, mp.x});
          check("pixel_y", {24'h0, pixel_y}, {24'h0, mp.y});
          check("frame_done", {31'h0, frame_done}, {31'h0, mp.fd});
        end
      end else if (frame_done) begin
        unexpected("frame_done without pixel");
      end
      if (err_partial) begin
        if (err_exp == 0) unexpected("err_partial");
        else begin
          err_exp--;
          total++;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_clk(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // Sends the first n bits of b, MSB first; SCL high and low for 4 CLK each.
  task automatic send_bits(input logic [7:0] b, input logic dc, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      MOSI = b[i];
      DC   = dc;
      wait_clk(4);
      SCL = 1'b1;
      wait_clk(4);
      SCL = 1'b0;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic dc);
    byte_t t;
    t.data = b;
    t.dc   = dc;
    byte_q.push_back(t);
    send_bits(b, dc, 8);
  endtask

  task automatic exp_pix(input logic [15:0] d, input logic [7:0] px, input logic [7:0] py,
                         input logic fd);
    pix_t t;
    t.data = d;
    t.x    = px;
    t.y    = py;
    t.fd   = fd;
    pix_q.push_back(t);
  endtask

  // Pixel stimulus for the 2..4 x 1..2 window, including the wrap pixel.
  logic [7:0] wx [7] = '{8'd2, 8'd3, 8'd4, 8'd2, 8'd3, 8'd4, 8'd2};
  logic [7:0] wy [7] = '{8'd1, 8'd1, 8'd1, 8'd2, 8'd2, 8'd2, 8'd1};
  logic [15:0] cdat [4] = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0};
  logic [7:0]  cx   [4] = '{8'd158, 8'd159, 8'd158, 8'd159};
  logic [7:0]  cy   [4] = '{8'd78, 8'd78, 8'd79, 8'd79};

  initial begin
    // Reset state.
    RST = 1'b1;
    wait_clk(3);
    check("rst byte_valid", {31'h0, byte_valid}, 32'h0);
    check("rst pixel_valid", {31'h0, pixel_valid}, 32'h0);
    check("rst err_partial", {31'h0, err_partial}, 32'h0);
    check("rst cur_cmd", {24'h0, cur_cmd}, 32'h0);
    check("rst flags", {30'h0, sleep_out, disp_on}, 32'h0);
    RST = 1'b0;
    wait_clk(3);

    // SLPOUT, DISPON.
    CS = 1'b0;
    wait_clk(2);
    send_byte(8'h11, 1'b0);
    send_byte(8'h29, 1'b0);
    wait_clk(4);
    check("sleep_out after 11", {31'h0, sleep_out}, 32'h1);
    check("disp_on after 29", {31'h0, disp_on}, 32'h1);
    check("cur_cmd after 29", {24'h0, cur_cmd}, 32'h29);

    // Window 2..4 x 1..2, six pixels plus one wrapped pixel.
    send_byte(8'h2A, 1'b0);
    send_byte(8'h00, 1'b1); send_byte(8'h02, 1'b1);
    send_byte(8'h00, 1'b1); send_byte(8'h04, 1'b1);
    send_byte(8'h2B, 1'b0);
    send_byte(8'h00, 1'b1); send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b1); send_byte(8'h02, 1'b1);
    send_byte(8'h2C, 1'b0);
    for (int k = 0; k < 7; k++) begin
      exp_pix(16'hF800, wx[k], wy[k], k == 5);
      send_byte(8'hF8, 1'b1);
      send_byte(8'h00, 1'b1);
    end
    wait_clk(2);
    CS = 1'b1;
    wait_clk(6);

    // 5-bit fragment, then a clean DISPOFF.
    CS = 1'b0;
    wait_clk(2);
    send_bits(8'hA5, 1'b0, 5);
    err_exp++;
    CS = 1'b1;
    wait_clk(8);
    check("err_partial seen", err_exp, 0);
    CS = 1'b0;
    wait_clk(2);
    send_byte(8'h28, 1'b0);
    wait_clk(4);
    check("disp_on after 28", {31'h0, disp_on}, 32'h0);
    check("cur_cmd after 28", {24'h0, cur_cmd}, 32'h28);
    check("sleep_out kept", {31'h0, sleep_out}, 32'h1);

    // Stale high byte is dropped by the intervening command.
    send_byte(8'h2C, 1'b0);
    send_byte(8'h55, 1'b1);
    send_byte(8'h00, 1'b0);
    send_byte(8'h2C, 1'b0);
    exp_pix(16'hABCD, 8'd2, 8'd1, 1'b0);
    send_byte(8'hAB, 1'b1);
    send_byte(8'hCD, 1'b1);
    wait_clk(4);
    check("cur_cmd after 2C", {24'h0, cur_cmd}, 32'h2C);

    // Reset while SCL is high during the 4th bit of a byte.
    send_bits(8'h3C, 1'b0, 3);
    MOSI = 1'b1;
    wait_clk(4);
    SCL = 1'b1;
    wait_clk(2);
    RST = 1'b1;
    #1;
    check("mid rst byte_data", {24'h0, byte_data}, 32'h0);
    check("mid rst byte_dc", {31'h0, byte_dc}, 32'h0);
    check("mid rst cur_cmd", {24'h0, cur_cmd}, 32'h0);
    check("mid rst pixel_data", {16'h0, pixel_data}, 32'h0);
    check("mid rst pixel_xy", {16'h0, pixel_x, pixel_y}, 32'h0);
    check("mid rst flags", {30'h0, sleep_out, disp_on}, 32'h0);
    wait_clk(1);
    RST = 1'b0;
    wait_clk(2);
    SCL = 1'b0;
    wait_clk(4);
    CS = 1'b1;
    wait_clk(6);
    CS = 1'b0;
    wait_clk(2);

    // Only start coordinates are sent, so the ends keep their reset values 159/79.
    send_byte(8'h2A, 1'b0);
    send_byte(8'h00, 1'b1); send_byte(8'h9E, 1'b1);
    send_byte(8'h2B, 1'b0);
    send_byte(8'h00, 1'b1); send_byte(8'h4E, 1'b1);
    send_byte(8'h2C, 1'b0);
    for (int k = 0; k < 4; k++) begin
      exp_pix(cdat[k], cx[k], cy[k], k == 3);
      send_byte(cdat[k][15:8], 1'b1);
      send_byte(cdat[k][7:0], 1'b1);
    end
    wait_clk(4);
    check("cur_cmd after reset run", {24'h0, cur_cmd}, 32'h2C);
    check("sleep_out after reset run", {31'h0, sleep_out}, 32'h0);
    CS = 1'b1;

    // Bounded drain, then everything expected must have been consumed.
    for (int i = 0; i < 100 && (byte_q.size() != 0 || pix_q.size() != 0); i++) wait_clk(1);
    wait_clk(10);
    check("bytes outstanding", byte_q.size(), 0);
    check("pixels outstanding", pix_q.size(), 0);
    check("err pulses outstanding", err_exp, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
